wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly upstream of the 32x32 register file; consumes MEM-stage results and produces the register file's write port (regWr, wr_addr, wr_data).
- Single-entry MEM/WB pipeline register plus writeback-source mux and load-data alignment/extension.
- Also keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, retire counter width.

Ports:
- clk  in  1  clock; stage register updates on posedge.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_regwr  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_wbsel  in  2  source: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_addr_lo  in  2  low bits of load address.
- in_alu_res  in  XLEN  ALU result.
- in_mem_rdata  in  XLEN  raw 32-bit memory word.
- in_pc4  in  XLEN  PC+4.
- hold  in  1  freeze stage (debug halt / external stall).
- flush  in  1  discard held entry.
- regWr  out  1  register-file write enable.
- wr_addr  out  5  register-file write address.
- wr_data  out  XLEN  register-file write data.
- retire_cnt  out  CNT_W  instructions retired.

Behaviour:
- Reset (reset==0 at posedge): wb_valid=0; stored fields=0; regWr=0, wr_addr=0, wr_data=0, retire_cnt=0. Applies mid-operation; the held entry is lost.
- in_ready = !wb_valid || !hold (combinational).
- Capture: on a posedge with in_valid && in_ready, the entry is stored. wb_valid=1 next cycle. Latency is one cycle from transfer to regWr.
- Drain: an entry is valid and not held for one cycle. It writes in that cycle and leaves wb_valid cleared unless a new entry is captured at the same edge. Back-to-back: one instruction per cycle.
- Outputs are combinational from the stored entry:
  - regWr = wb_valid && !hold && stored regwr && (rd != 0). x0 is never written.
  - wr_addr = stored rd whenever wb_valid, else 0.
  - wr_data = selected source whenever wb_valid, else 0.
- The register file samples on the following negedge, so outputs are stable for the half-cycle.
- Load alignment, computed at capture and stored pre-extended:
  - Byte lane = addr_lo.
  - Half lane = addr_lo[1]; addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Undefined funct3 values behave as LW.
- hold: entry and outputs frozen; regWr=0 while hold=1; no capture unless the stage is empty.
- flush: at posedge, wb_valid<=0 and no capture that edge, even if in_valid. Flush has priority over hold and capture. A flushed entry is not written or counted.
- retire_cnt increments by 1 for each draining entry, including entries with regwr=0 or rd=0. Wraps from all-ones to 0.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds inputs fwd_rs1_addr[4:0] and fwd_rs2_addr[4:0], and outputs fwd_rs1_hit, fwd_rs2_hit, fwd_data[XLEN].
  - hit = regWr && (wr_addr == fwd_rsN_addr).
  - fwd_data = wr_data.
  - Used by the EX-stage bypass mux.
- Undefined: the ports are absent; no forwarding logic.

Decomposition:
- Package wb_pkg holds:
  - WBSEL_ALU/LOAD/PC4 constants.
  - LOAD_LB/LH/LW/LBU/LHU funct3 constants.
  - XLEN default.
- Sub-module load_align (combinational: rdata, addr_lo, funct3 -> extended data) is natural and reused by the MEM-stage test model.

Test Plan:
- ALU write: ALU 0x1234_5678, rd=5, regwr=1 -> next cycle regWr=1, wr_addr=5, wr_data=0x12345678; retire_cnt 0->1.
- Load extension: rdata 0x80FF_7F01.
  - LB at addr_lo=3 -> 0xFFFFFF80.
  - LBU at addr_lo=1 -> 0x0000007F.
  - LH at addr_lo=2 -> 0xFFFF80FF.
  - LHU at addr_lo=0 -> 0x00007F01.
- x0 / no-write: rd=0, regwr=1, ALU=0xDEAD -> regWr=0, retire_cnt still increments. regwr=0 with rd=7 -> regWr=0, counted.
- Hold then flush: capture JAL (wbsel=10, pc4=0x104, rd=1) with hold=1 for 3 cycles -> regWr=0, in_ready=0. Then flush=1 -> wb_valid=0, no write, retire_cnt unchanged.
- Reset mid-stream: 3 back-to-back writes, reset=0 on the second -> all outputs 0, retire_cnt=0, the third write happens only after reset=1 and a new capture.
- Counter wrap: force retire_cnt to all-ones, retire one -> 0. With WB_FWD_EN, fwd_rs1_addr=5 during the ALU test -> fwd_rs1_hit=1, fwd_data=0x12345678.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
//============================================================================
// Module   : wb_pkg
// Brief    : Shared constants for the writeback stage (source select, load
//            funct3 codes, default datapath width).
// Revision : 1.0 - initial release
//============================================================================
package wb_pkg;

    localparam int DEF_XLEN = 32;

    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_PC4  = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
//============================================================================
// Module   : wb_stage_if
// Brief    : MEM -> WB transfer bundle (valid/ready handshake plus payload).
// Revision : 1.0 - initial release
//============================================================================
interface wb_stage_if #(
    parameter int XLEN = wb_pkg::DEF_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic            in_regwr;
    logic [4:0]      in_rd;
    logic [1:0]      in_wbsel;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_alu_res;
    logic [XLEN-1:0] in_mem_rdata;
    logic [XLEN-1:0] in_pc4;

    modport master (
        output in_valid, in_regwr, in_rd, in_wbsel, in_funct3, in_addr_lo,
               in_alu_res, in_mem_rdata, in_pc4,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_regwr, in_rd, in_wbsel, in_funct3, in_addr_lo,
               in_alu_res, in_mem_rdata, in_pc4,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
//============================================================================
// Module   : load_align
// Brief    : Selects the addressed byte/half of a memory word and extends it.
// Revision : 1.0 - initial release
//============================================================================
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  wire logic [XLEN-1:0] i_rdata,
    input  wire logic [1:0]      i_addr_lo,
    input  wire logic [2:0]      i_funct3,
    output logic      [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halfword accesses use only the upper address bit.
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            LOAD_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LOAD_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LOAD_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            LOAD_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
//============================================================================
// Module   : wb_stage
// Brief    : MEM/WB register, writeback source mux and retire counter
//            driving the register-file write port.
// Options  : WB_FWD_EN - adds EX-stage bypass hit/data outputs.
// Revision : 1.0 - initial release
//============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    wb_stage_if.slave             mem,
    input  wire logic             hold,
    input  wire logic             flush,
`ifdef WB_FWD_EN
    input  wire logic [4:0]       fwd_rs1_addr,
    input  wire logic [4:0]       fwd_rs2_addr,
    output logic                  fwd_rs1_hit,
    output logic                  fwd_rs2_hit,
    output logic [XLEN-1:0]       fwd_data,
`endif
    output logic                  regWr,
    output logic [4:0]            wr_addr,
    output logic [XLEN-1:0]       wr_data,
    output logic [CNT_W-1:0]      retire_cnt
);

    logic             r_valid;
    logic             r_regwr;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_data;
    logic [CNT_W-1:0] r_retire_cnt;

    logic             w_in_ready;
    logic             w_capture;
    logic             w_drain;
    logic [XLEN-1:0]  w_load_data;
    logic [XLEN-1:0]  w_sel_data;

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata   (mem.in_mem_rdata),
        .i_addr_lo (mem.in_addr_lo),
        .i_funct3  (mem.in_funct3),
        .o_data    (w_load_data)
    );

    always_comb begin
        case (mem.in_wbsel)
            WBSEL_LOAD: w_sel_data = w_load_data;
            WBSEL_PC4:  w_sel_data = mem.in_pc4;
            WBSEL_ALU:  w_sel_data = mem.in_alu_res;
            default:    w_sel_data = mem.in_alu_res;
        endcase
    end

    assign w_in_ready = !r_valid || !hold;
    assign w_capture  = mem.in_valid && w_in_ready;
    // A flushed entry neither writes nor retires, even when not held.
    assign w_drain    = r_valid && !hold && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_regwr      <= 1'b0;
            r_rd         <= 5'd0;
            r_data       <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_drain) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
                r_regwr <= mem.in_regwr;
                r_rd    <= mem.in_rd;
                r_data  <= w_sel_data;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign mem.in_ready = w_in_ready;
    assign regWr        = w_drain && r_regwr && (r_rd != 5'd0);
    assign wr_addr      = r_valid ? r_rd : 5'd0;
    assign wr_data      = r_valid ? r_data : '0;
    assign retire_cnt   = r_retire_cnt;

`ifdef WB_FWD_EN
    assign fwd_rs1_hit = regWr && (wr_addr == fwd_rs1_addr);
    assign fwd_rs2_hit = regWr && (wr_addr == fwd_rs2_addr);
    assign fwd_data    = wr_data;
`else
    // Bypass outputs are absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage (directed table, corner
//            sequences, randomized traffic against a behavioural model).
// Revision : 1.0 - initial release
//============================================================================
module tb_wb_stage;
    import wb_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hold = 1'b0, flush = 1'b0;
    logic hold2 = 1'b0, flush2 = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(XLEN)) mif ();
    wb_stage_if #(.XLEN(XLEN)) mif2 ();

    logic             regWr, regWr2;
    logic [4:0]       wr_addr, wr_addr2;
    logic [XLEN-1:0]  wr_data, wr_data2;
    logic [CNT_W-1:0] retire_cnt;
    logic [3:0]       retire_cnt2;

`ifdef WB_FWD_EN
    logic [4:0]      fwd_rs1_addr = 5'd0, fwd_rs2_addr = 5'd0;
    logic            fwd_rs1_hit, fwd_rs2_hit, fwd2_rs1_hit, fwd2_rs2_hit;
    logic [XLEN-1:0] fwd_data, fwd2_data;
`endif

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mif),
        .hold       (hold),
        .flush      (flush),
`ifdef WB_FWD_EN
        .fwd_rs1_addr (fwd_rs1_addr),
        .fwd_rs2_addr (fwd_rs2_addr),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_data     (fwd_data),
`endif
        .regWr      (regWr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .retire_cnt (retire_cnt)
    );

    // Narrow-counter instance so wrap-around is reachable in a few cycles.
    wb_stage #(.XLEN(XLEN), .CNT_W(4)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .mem        (mif2),
        .hold       (hold2),
        .flush      (flush2),
`ifdef WB_FWD_EN
        .fwd_rs1_addr (5'd0),
        .fwd_rs2_addr (5'd0),
        .fwd_rs1_hit  (fwd2_rs1_hit),
        .fwd_rs2_hit  (fwd2_rs2_hit),
        .fwd_data     (fwd2_data),
`endif
        .regWr      (regWr2),
        .wr_addr    (wr_addr2),
        .wr_data    (wr_data2),
        .retire_cnt (retire_cnt2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference value of a writeback, from the source/load rules.
    function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [2:0] f3,
                                             input logic [1:0] alo, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [31:0] pc4);
        longint unsigned w, b, h;
        w = 64'(rdata);
        if (sel == 2'b10) return pc4;
        if (sel != 2'b01) return alu;
        b = (w >> (8 * int'(alo))) % 256;
        h = (w >> (16 * (int'(alo) / 2))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return rdata;
        endcase
    endfunction

    // Behavioural model: at most one pending instruction.
    logic        m_v = 1'b0, m_regwr = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [63:0] m_cnt = 64'd0;

    task automatic tick();
        logic e_wr, rdy, retires;
        #1;
        e_wr = m_v && !hold && !flush && m_regwr && (m_rd != 5'd0);
        check("regWr", 64'(regWr), 64'(e_wr));
        check("wr_addr", 64'(wr_addr), m_v ? 64'(m_rd) : 64'd0);
        check("wr_data", 64'(wr_data), m_v ? 64'(m_data) : 64'd0);
        check("in_ready", 64'(mif.in_ready), 64'(!m_v || !hold));
        check("retire_cnt", retire_cnt, m_cnt);
`ifdef WB_FWD_EN
        check("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'(e_wr && (m_rd == fwd_rs1_addr)));
        check("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'(e_wr && (m_rd == fwd_rs2_addr)));
        check("fwd_data", 64'(fwd_data), m_v ? 64'(m_data) : 64'd0);
`endif
        @(posedge clk);
        if (!reset) begin
            m_v = 1'b0; m_regwr = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_cnt = 64'd0;
        end else begin
            rdy     = !m_v || !hold;
            retires = m_v && !hold && !flush;
            if (retires) m_cnt = m_cnt + 64'd1;
            if (flush) m_v = 1'b0;
            else if (mif.in_valid && rdy) begin
                m_v = 1'b1; m_regwr = mif.in_regwr; m_rd = mif.in_rd;
                m_data = ref_data(mif.in_wbsel, mif.in_funct3, mif.in_addr_lo,
                                  mif.in_alu_res, mif.in_mem_rdata, mif.in_pc4);
            end else if (retires) m_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
        mif.in_valid = v; mif.in_regwr = rw; mif.in_rd = rd; mif.in_wbsel = sel;
        mif.in_funct3 = f3; mif.in_addr_lo = alo; mif.in_alu_res = alu;
        mif.in_mem_rdata = rdata; mif.in_pc4 = pc4;
    endtask

    typedef struct {
        logic        regwr;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        exp_wr;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 5'd5,  WBSEL_ALU,  LOAD_LW,  2'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd5,  32'h1234_5678};
        tbl[1]  = '{1'b1, 5'd10, WBSEL_LOAD, LOAD_LB,  2'd3, 32'h0, 32'h0, 1'b1, 5'd10, 32'hFFFF_FF80};
        tbl[2]  = '{1'b1, 5'd11, WBSEL_LOAD, LOAD_LBU, 2'd1, 32'h0, 32'h0, 1'b1, 5'd11, 32'h0000_007F};
        tbl[3]  = '{1'b1, 5'd12, WBSEL_LOAD, LOAD_LH,  2'd2, 32'h0, 32'h0, 1'b1, 5'd12, 32'hFFFF_80FF};
        tbl[4]  = '{1'b1, 5'd13, WBSEL_LOAD, LOAD_LHU, 2'd0, 32'h0, 32'h0, 1'b1, 5'd13, 32'h0000_7F01};
        tbl[5]  = '{1'b1, 5'd0,  WBSEL_ALU,  LOAD_LW,  2'd0, 32'h0000_DEAD, 32'h0, 1'b0, 5'd0, 32'h0000_DEAD};
        tbl[6]  = '{1'b0, 5'd7,  WBSEL_ALU,  LOAD_LW,  2'd0, 32'h0000_0055, 32'h0, 1'b0, 5'd7, 32'h0000_0055};
        tbl[7]  = '{1'b1, 5'd1,  WBSEL_PC4,  LOAD_LW,  2'd0, 32'h0, 32'h0000_0104, 1'b1, 5'd1, 32'h0000_0104};
        tbl[8]  = '{1'b1, 5'd3,  2'b11,      LOAD_LB,  2'd0, 32'h0000_AAAA, 32'h0, 1'b1, 5'd3, 32'h0000_AAAA};
        tbl[9]  = '{1'b1, 5'd14, WBSEL_LOAD, LOAD_LW,  2'd2, 32'h0, 32'h0, 1'b1, 5'd14, 32'h80FF_7F01};
        tbl[10] = '{1'b1, 5'd15, WBSEL_LOAD, 3'b011,   2'd1, 32'h0, 32'h0, 1'b1, 5'd15, 32'h80FF_7F01};
        tbl[11] = '{1'b1, 5'd16, WBSEL_LOAD, LOAD_LH,  2'd3, 32'h0, 32'h0, 1'b1, 5'd16, 32'hFFFF_80FF};

        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        mif2.in_valid = 1'b0; mif2.in_regwr = 1'b1; mif2.in_rd = 5'd2; mif2.in_wbsel = 2'd0;
        mif2.in_funct3 = 3'd2; mif2.in_addr_lo = 2'd0; mif2.in_alu_res = 32'h1;
        mif2.in_mem_rdata = 32'h0; mif2.in_pc4 = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_regWr", 64'(regWr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_retire_cnt", retire_cnt, 64'd0);
        check("rst_in_ready", 64'(mif.in_ready), 64'd1);
        reset = 1'b1;

        // Directed table: capture, then check the draining cycle.
        for (int i = 0; i < 12; i++) begin
`ifdef WB_FWD_EN
            fwd_rs1_addr = tbl[i].rd;
            fwd_rs2_addr = tbl[i].rd + 5'd1;
`endif
            drive(1'b1, tbl[i].regwr, tbl[i].rd, tbl[i].wbsel, tbl[i].f3, tbl[i].alo,
                  tbl[i].alu, 32'h80FF_7F01, tbl[i].pc4);
            tick();
            mif.in_valid = 1'b0;
            #1;
            check($sformatf("tbl%0d_regWr", i), 64'(regWr), 64'(tbl[i].exp_wr));
            check($sformatf("tbl%0d_wr_addr", i), 64'(wr_addr), 64'(tbl[i].exp_addr));
            check($sformatf("tbl%0d_wr_data", i), 64'(wr_data), 64'(tbl[i].exp_data));
`ifdef WB_FWD_EN
            check($sformatf("tbl%0d_fwd_rs1_hit", i), 64'(fwd_rs1_hit), 64'(tbl[i].exp_wr));
            check($sformatf("tbl%0d_fwd_rs2_hit", i), 64'(fwd_rs2_hit), 64'd0);
            check($sformatf("tbl%0d_fwd_data", i), 64'(fwd_data), 64'(tbl[i].exp_data));
`endif
            tick();
            #1;
            check($sformatf("tbl%0d_retire_cnt", i), retire_cnt, 64'(i + 1));
        end

        // Hold a JAL for three cycles, then flush it.
        drive(1'b1, 1'b1, 5'd1, WBSEL_PC4, LOAD_LW, 2'd0, 32'h0, 32'h0, 32'h0000_0104);
        tick();
        hold = 1'b1;
        drive(1'b1, 1'b1, 5'd9, WBSEL_ALU, LOAD_LW, 2'd0, 32'h77, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_regWr", 64'(regWr), 64'd0);
            check("hold_in_ready", 64'(mif.in_ready), 64'd0);
            check("hold_wr_data", 64'(wr_data), 64'h104);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; hold = 1'b0; mif.in_valid = 1'b0;
        #1;
        check("flush_regWr", 64'(regWr), 64'd0);
        check("flush_wr_addr", 64'(wr_addr), 64'd0);
        tick();
        #1;
        check("flush_retire_cnt", retire_cnt, 64'd12);

        // Reset arrives while the second of three writes is presented.
        drive(1'b1, 1'b1, 5'd20, WBSEL_ALU, LOAD_LW, 2'd0, 32'h20, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 5'd21, WBSEL_ALU, LOAD_LW, 2'd0, 32'h21, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mif.in_valid = 1'b0;
        #1;
        check("midrst_regWr", 64'(regWr), 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        check("midrst_retire_cnt", retire_cnt, 64'd0);
        drive(1'b1, 1'b1, 5'd22, WBSEL_ALU, LOAD_LW, 2'd0, 32'h22, 32'h0, 32'h0);
        tick();
        mif.in_valid = 1'b0;
        #1;
        check("postrst_regWr", 64'(regWr), 64'd1);
        check("postrst_wr_addr", 64'(wr_addr), 64'd22);
        tick();
        #1;
        check("postrst_retire_cnt", retire_cnt, 64'd1);

        // Counter wrap on the 4-bit instance: 16 edges retire 15, one more wraps.
        mif2.in_valid = 1'b1;
        repeat (16) tick();
        #1;
        check("wrap_cnt_full", 64'(retire_cnt2), 64'd15);
        tick();
        mif2.in_valid = 1'b0;
        #1;
        check("wrap_cnt_zero", 64'(retire_cnt2), 64'd0);
        tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) != 0);
            hold  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom);
`ifdef WB_FWD_EN
            fwd_rs1_addr = 5'($urandom_range(0, 31));
            fwd_rs2_addr = m_rd;
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
